tcam_ctrl: RTL and testbench

Command sequencer in front of the 64-entry x 28-bit TCAM memory (4 blocks of 7-bit sub-keys, 128 rows x 64 bits each, byte-masked 32-bit writes, 6-bit priority-encoded match address).
- Holds a shadow table of 64 ternary patterns (key, care, valid).
- Expands patterns into per-row match bitmaps and sweeps them into the TCAM in 8-entry groups.
- Sequences search operations.
- Serves one requester (RoCC glue) over a valid/ready request/response pair.

---
 rtl/tcam_ctrl_pkg.sv | 40 ++++
 rtl/tcam_ctrl_if.sv | 23 ++
 rtl/tcam_group_match.sv | 21 ++
 rtl/tcam_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_tcam_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/tcam_ctrl_pkg.sv
// Shared types and constants for the TCAM command sequencer.
package tcam_ctrl_pkg;

    localparam int NUM_BLK = 4;
    localparam int SUB_W   = 7;
    localparam int ROWS    = 128;
    localparam int ENTRIES = 64;
    localparam int GRP_SZ  = 8;
    localparam int ADDR_W  = 28;
    localparam int KEY_W   = NUM_BLK * SUB_W;
    localparam int DATA_W  = 32;

    typedef enum logic [1:0] {
        OP_LOAD       = 2'd0,
        OP_COMMIT     = 2'd1,
        OP_SEARCH     = 2'd2,
        OP_INVALIDATE = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_SRCH  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [KEY_W-1:0] care;
        logic             valid;
    } entry_t;

    // A TCAM row matches a sub-key when every cared bit agrees.
    function automatic logic sub_match(input logic [SUB_W-1:0] row,
                                       input logic [SUB_W-1:0] key,
                                       input logic [SUB_W-1:0] care);
        return (((row ^ key) & care) == {SUB_W{1'b0}});
    endfunction

endpackage

// File: rtl/tcam_ctrl_if.sv
// Request/response handshake between the requester and the TCAM sequencer.
interface tcam_ctrl_if;
    logic        in_req_valid;
    logic        out_req_ready;
    logic [1:0]  in_req_op;
    logic [5:0]  in_req_idx;
    logic [27:0] in_req_key;
    logic [27:0] in_req_care;
    logic        out_resp_valid;
    logic        in_resp_ready;
    logic [1:0]  out_resp_op;
    logic [5:0]  out_resp_pma;

    modport master (
        output in_req_valid, in_req_op, in_req_idx, in_req_key, in_req_care, in_resp_ready,
        input  out_req_ready, out_resp_valid, out_resp_op, out_resp_pma
    );

    modport slave (
        input  in_req_valid, in_req_op, in_req_idx, in_req_key, in_req_care, in_resp_ready,
        output out_req_ready, out_resp_valid, out_resp_op, out_resp_pma
    );
endinterface

// File: rtl/tcam_group_match.sv
// Builds one TCAM row byte: bit j set when entry j of the group matches the row in block blk.
module tcam_group_match
    import tcam_ctrl_pkg::*;
(
    input  entry_t [GRP_SZ-1:0] ents,
    input  logic   [1:0]        blk,
    input  logic   [SUB_W-1:0]  row,
    output logic   [GRP_SZ-1:0] row_byte
);

    // Per-entry ternary compare of the row against the selected sub-key slice.
    always_comb begin
        row_byte = {GRP_SZ{1'b0}};
        for (int j = 0; j < GRP_SZ; j++) begin
            row_byte[j] = ents[j].valid &&
                          sub_match(row, ents[j].key[blk*SUB_W +: SUB_W],
                                    ents[j].care[blk*SUB_W +: SUB_W]);
        end
    end

endmodule

// File: rtl/tcam_ctrl.sv
// TCAM command sequencer: shadow pattern table, group sweep into TCAM rows, search sequencing.
// Optional perf counters under `TCAM_CTRL_PERF_EN.
module tcam_ctrl
    import tcam_ctrl_pkg::*;
#(
    parameter int SEARCH_LAT = 2
) (
    input  logic              in_clk,
    input  logic              in_rstn,
    tcam_ctrl_if.slave        req,
    output logic              out_tcam_csb,
    output logic              out_tcam_web,
    output logic [3:0]        out_tcam_wmask,
    output logic [ADDR_W-1:0] out_tcam_addr,
    output logic [DATA_W-1:0] out_tcam_wdata,
`ifdef TCAM_CTRL_PERF_EN
    output logic [31:0]       out_perf_search,
    output logic [31:0]       out_perf_commit,
`endif
    input  logic [5:0]        in_tcam_pma
);

    localparam int LAT_W = (SEARCH_LAT < 1) ? 1 : $clog2(SEARCH_LAT + 1);

    state_e state_r, state_s;
    logic [8:0] cnt_r, cnt_s;
    logic [2:0] grp_r, grp_s;
    logic [LAT_W-1:0] lat_r, lat_s;
    logic req_ready_r, req_ready_s, resp_valid_r, resp_valid_s;
    op_e resp_op_r, resp_op_s;
    logic [5:0] resp_pma_r, resp_pma_s;
    logic csb_r, csb_s, web_r, web_s;
    logic [3:0] wmask_r, wmask_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [DATA_W-1:0] wdata_r, wdata_s;

    entry_t [ENTRIES-1:0] shadow_r;
    entry_t [GRP_SZ-1:0]  grp_ents_s;
    logic [2:0] m_grp_s;
    logic [8:0] m_cnt_s;
    logic [7:0] row_byte_s;
    logic accept_s, load_s, inval_s;
    op_e req_op_s;

    assign accept_s = req.in_req_valid && req_ready_r;
    assign req_op_s = op_e'(req.in_req_op);

    // During accept the match path already prepares write 0 of the requested group.
    assign m_grp_s    = (state_r == ST_SWEEP) ? grp_r : req.in_req_idx[2:0];
    assign m_cnt_s    = (state_r == ST_SWEEP) ? cnt_r : 9'd0;
    assign grp_ents_s = shadow_r[{m_grp_s, 3'b000} +: GRP_SZ];

    tcam_group_match u_match (
        .ents     (grp_ents_s),
        .blk      (m_cnt_s[8:7]),
        .row      (m_cnt_s[6:0]),
        .row_byte (row_byte_s)
    );

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_s = state_r;  cnt_s = cnt_r;  grp_s = grp_r;  lat_s = lat_r;
        req_ready_s = req_ready_r;  resp_valid_s = resp_valid_r;
        resp_op_s = resp_op_r;  resp_pma_s = resp_pma_r;
        csb_s = 1'b1;  web_s = 1'b1;  wmask_s = 4'b0000;
        addr_s = addr_r;  wdata_s = wdata_r;
        load_s = 1'b0;  inval_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    req_ready_s = 1'b0;
                    case (req_op_s)
                        OP_COMMIT: begin
                            grp_s   = req.in_req_idx[2:0];
                            cnt_s   = 9'd1;
                            csb_s   = 1'b0;
                            web_s   = 1'b0;
                            wmask_s = 4'b0001 << m_grp_s[1:0];
                            addr_s  = {{(ADDR_W-10){1'b0}}, m_cnt_s, m_grp_s[2]};
                            wdata_s = {4{row_byte_s}};
                            state_s = ST_SWEEP;
                        end
                        OP_SEARCH: begin
                            csb_s   = 1'b0;
                            addr_s  = req.in_req_key;
                            lat_s   = {LAT_W{1'b0}};
                            state_s = ST_SRCH;
                        end
                        default: begin
                            load_s       = (req_op_s == OP_LOAD);
                            inval_s      = (req_op_s == OP_INVALIDATE);
                            resp_valid_s = 1'b1;
                            resp_op_s    = req_op_s;
                            resp_pma_s   = 6'd0;
                            state_s      = ST_RESP;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                // The counter wraps to 0 only after write 511 has been issued.
                if (cnt_r == 9'd0) begin
                    resp_valid_s = 1'b1;
                    resp_op_s    = OP_COMMIT;
                    resp_pma_s   = 6'd0;
                    state_s      = ST_RESP;
                end else begin
                    csb_s   = 1'b0;
                    web_s   = 1'b0;
                    wmask_s = 4'b0001 << m_grp_s[1:0];
                    addr_s  = {{(ADDR_W-10){1'b0}}, m_cnt_s, m_grp_s[2]};
                    wdata_s = {4{row_byte_s}};
                    cnt_s   = cnt_r + 9'd1;
                end
            end
            ST_SRCH: begin
                if (lat_r == LAT_W'(SEARCH_LAT)) begin
                    resp_valid_s = 1'b1;
                    resp_op_s    = OP_SEARCH;
                    resp_pma_s   = in_tcam_pma;
                    state_s      = ST_RESP;
                end else begin
                    lat_s = lat_r + {{(LAT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RESP: begin
                if (req.in_resp_ready) begin
                    resp_valid_s = 1'b0;
                    req_ready_s  = 1'b1;
                    state_s      = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer and TCAM-side output registers.
    always_ff @(posedge in_clk or negedge in_rstn) begin
        if (!in_rstn) begin
            state_r <= ST_IDLE;  cnt_r <= 9'd0;  grp_r <= 3'd0;  lat_r <= {LAT_W{1'b0}};
            req_ready_r <= 1'b1;  resp_valid_r <= 1'b0;
            resp_op_r <= OP_LOAD;  resp_pma_r <= 6'd0;
            csb_r <= 1'b1;  web_r <= 1'b1;  wmask_r <= 4'b0000;
            addr_r <= {ADDR_W{1'b0}};  wdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_s;  cnt_r <= cnt_s;  grp_r <= grp_s;  lat_r <= lat_s;
            req_ready_r <= req_ready_s;  resp_valid_r <= resp_valid_s;
            resp_op_r <= resp_op_s;  resp_pma_r <= resp_pma_s;
            csb_r <= csb_s;  web_r <= web_s;  wmask_r <= wmask_s;
            addr_r <= addr_s;  wdata_r <= wdata_s;
        end
    end

    // Shadow pattern table updates from LOAD and INVALIDATE.
    always_ff @(posedge in_clk or negedge in_rstn) begin
        if (!in_rstn) begin
            shadow_r <= '0;
        end else if (load_s) begin
            shadow_r[req.in_req_idx] <= '{key: req.in_req_key, care: req.in_req_care, valid: 1'b1};
        end else if (inval_s) begin
            shadow_r[req.in_req_idx].valid <= 1'b0;
        end else begin
            shadow_r <= shadow_r;
        end
    end

`ifdef TCAM_CTRL_PERF_EN
    logic [31:0] perf_search_r, perf_commit_r;

    // Completed-operation counters, bumped on the response handshake.
    always_ff @(posedge in_clk or negedge in_rstn) begin
        if (!in_rstn) begin
            perf_search_r <= 32'd0;
            perf_commit_r <= 32'd0;
        end else if (resp_valid_r && req.in_resp_ready) begin
            perf_search_r <= perf_search_r + ((resp_op_r == OP_SEARCH) ? 32'd1 : 32'd0);
            perf_commit_r <= perf_commit_r + ((resp_op_r == OP_COMMIT) ? 32'd1 : 32'd0);
        end else begin
            perf_search_r <= perf_search_r;
            perf_commit_r <= perf_commit_r;
        end
    end

    assign out_perf_search = perf_search_r;
    assign out_perf_commit = perf_commit_r;
`endif

    assign req.out_req_ready  = req_ready_r;
    assign req.out_resp_valid = resp_valid_r;
    assign req.out_resp_op    = resp_op_r;
    assign req.out_resp_pma   = resp_pma_r;
    assign out_tcam_csb       = csb_r;
    assign out_tcam_web       = web_r;
    assign out_tcam_wmask     = wmask_r;
    assign out_tcam_addr      = addr_r;
    assign out_tcam_wdata     = wdata_r;

endmodule

// File: tb/tb_tcam_ctrl.sv
// Directed scoreboard bench for tcam_ctrl with a behavioural pattern model and TCAM search stub.
module tb_tcam_ctrl;

    logic        in_clk = 1'b0;
    logic        in_rstn;
    logic        tcam_csb, tcam_web;
    logic [3:0]  tcam_wmask;
    logic [27:0] tcam_addr;
    logic [31:0] tcam_wdata;
    logic [5:0]  in_tcam_pma = 6'h15;
    logic        srch_d = 1'b0;
    logic [5:0]  model_pma = 6'h00;

    logic [27:0] m_key  [64];
    logic [27:0] m_care [64];
    logic        m_valid[64];
    logic [2:0]  cur_g;
    logic [27:0] cur_key;
    logic [7:0]  sb_q[$];
    int n_chk = 0, n_pass = 0, n_fail = 0;

    tcam_ctrl_if bus();

    tcam_ctrl #(.SEARCH_LAT(2)) dut (
        .in_clk         (in_clk),
        .in_rstn        (in_rstn),
        .req            (bus),
        .out_tcam_csb   (tcam_csb),
        .out_tcam_web   (tcam_web),
        .out_tcam_wmask (tcam_wmask),
        .out_tcam_addr  (tcam_addr),
        .out_tcam_wdata (tcam_wdata),
        .in_tcam_pma    (in_tcam_pma)
    );

    always #5 in_clk = ~in_clk;

    // TCAM search stub: presents the model answer exactly two cycles after the drive cycle.
    always @(posedge in_clk) begin
        srch_d      <= !tcam_csb && tcam_web;
        in_tcam_pma <= srch_d ? model_pma : 6'h15;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [2:0] g, input logic [8:0] c);
        logic [7:0]  r;
        logic [27:0] k, m;
        logic [5:0]  e;
        r = 8'h00;
        for (int j = 0; j < 8; j++) begin
            e = {g, 3'(j)};
            k = m_key[e] >> (7 * c[8:7]);
            m = m_care[e] >> (7 * c[8:7]);
            r[j] = m_valid[e] && (((c[6:0] ^ k[6:0]) & m[6:0]) == 7'd0);
        end
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 64; i++) begin
            m_key[i] = 28'd0; m_care[i] = 28'd0; m_valid[i] = 1'b0;
        end
        sb_q.delete();
    endtask

    task automatic send(input logic [1:0] op, input logic [5:0] idx,
                        input logic [27:0] key, input logic [27:0] care);
        int w;
        w = 0;
        while (!bus.out_req_ready && w < 20) begin
            @(negedge in_clk);
            w++;
        end
        chk("req_ready", bus.out_req_ready, 1);
        bus.in_req_valid = 1'b1; bus.in_req_op = op; bus.in_req_idx = idx;
        bus.in_req_key = key;    bus.in_req_care = care;
        case (op)
            2'd0: begin m_key[idx] = key; m_care[idx] = care; m_valid[idx] = 1'b1; sb_q.push_back({op, 6'd0}); end
            2'd1: begin cur_g = idx[2:0]; sb_q.push_back({op, 6'd0}); end
            2'd2: begin cur_key = key; sb_q.push_back({op, model_pma}); end
            default: begin m_valid[idx] = 1'b0; sb_q.push_back({op, 6'd0}); end
        endcase
        @(posedge in_clk);
        #1 bus.in_req_valid = 1'b0;
    endtask

    task automatic check_write(input int n);
        logic [8:0] c;
        c = n[8:0];
        chk("wr_ctl", {tcam_wmask, tcam_addr}, {4'b0001 << cur_g[1:0], 18'd0, c, cur_g[2]});
        chk("wr_data", tcam_wdata, {4{exp_byte(cur_g, c)}});
    endtask

    task automatic wait_resp(input int lat, input int hold);
        int k, n_wr, n_drv;
        logic seen;
        logic [7:0] exp;
        k = 0; n_wr = 0; n_drv = 0; seen = 1'b0;
        while (!seen && k < 600) begin
            @(negedge in_clk);
            k++;
            if (!tcam_csb && !tcam_web) begin
                check_write(n_wr);
                n_wr++;
            end
            if (!tcam_csb && tcam_web) begin
                chk("srch_addr", tcam_addr, cur_key);
                chk("srch_cycle", k, 1);
                n_drv++;
            end
            seen = bus.out_resp_valid;
        end
        chk("resp_latency", k, lat);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hFF;
        chk("n_writes", n_wr, (exp[7:6] == 2'd1) ? 512 : 0);
        chk("n_drives", n_drv, (exp[7:6] == 2'd2) ? 1 : 0);
        chk("bus_idle", {tcam_csb, tcam_wmask}, 5'b10000);
        chk("resp", {bus.out_resp_op, bus.out_resp_pma}, exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge in_clk);
            chk("resp_hold", {bus.out_resp_valid, bus.out_resp_op, bus.out_resp_pma, bus.out_req_ready},
                {1'b1, exp, 1'b0});
        end
        bus.in_resp_ready = 1'b1;
        @(posedge in_clk);
        #1 bus.in_resp_ready = 1'b0;
        @(negedge in_clk);
        chk("resp_done", {bus.out_resp_valid, bus.out_req_ready}, 2'b01);
    endtask

    initial begin
        int n_wr;
        in_rstn = 1'b0;
        bus.in_req_valid = 1'b0; bus.in_req_op = 2'd0; bus.in_req_idx = 6'd0;
        bus.in_req_key = 28'd0;  bus.in_req_care = 28'd0; bus.in_resp_ready = 1'b0;
        clear_model();
        repeat (2) @(negedge in_clk);
        chk("rst_req", {bus.out_req_ready, bus.out_resp_valid, bus.out_resp_op, bus.out_resp_pma}, 10'b10_0000_0000);
        chk("rst_tcam", {tcam_csb, tcam_web, tcam_wmask, tcam_addr, tcam_wdata}, {2'b11, 64'd0});
        in_rstn = 1'b1;
        @(negedge in_clk);

        // Single pattern in group 0
        send(2'd0, 6'd0, 28'h0000005, 28'h000007F);  wait_resp(1, 0);
        send(2'd1, 6'd0, 28'd0, 28'd0);              wait_resp(513, 0);

        // Pattern with care in several blocks, upper half-group and lane 1
        send(2'd0, 6'd45, 28'h1A2B3C4, 28'hFF00F0F); wait_resp(1, 0);
        send(2'd1, 6'd5, 28'd0, 28'd0);              wait_resp(513, 0);

        // Searches; the second holds the response for five cycles
        model_pma = 6'h2A;
        send(2'd2, 6'd0, 28'h1234567, 28'd0);        wait_resp(4, 0);
        model_pma = 6'h13;
        send(2'd2, 6'd0, 28'h0ABCDEF, 28'd0);        wait_resp(4, 5);

        // Loaded then invalidated entry must not appear in the sweep
        send(2'd0, 6'd3, 28'h0000000, 28'h0000000);  wait_resp(1, 0);
        send(2'd3, 6'd3, 28'd0, 28'd0);              wait_resp(1, 0);
        send(2'd1, 6'd0, 28'd0, 28'd0);              wait_resp(513, 0);

        // Reset part-way through a sweep
        send(2'd1, 6'd0, 28'd0, 28'd0);
        n_wr = 0;
        for (int k = 0; k < 400 && n_wr < 200; k++) begin
            @(negedge in_clk);
            if (!tcam_csb && !tcam_web) begin
                check_write(n_wr);
                n_wr++;
            end
        end
        chk("pre_rst_writes", n_wr, 200);
        in_rstn = 1'b0;
        #1;
        chk("mid_rst", {tcam_csb, tcam_wmask, bus.out_resp_valid, bus.out_req_ready}, 7'b1_0000_01);
        clear_model();
        @(negedge in_clk);
        in_rstn = 1'b1;
        @(negedge in_clk);
        chk("post_rst_ready", {bus.out_req_ready, bus.out_resp_valid}, 2'b10);
        send(2'd1, 6'd0, 28'd0, 28'd0);              wait_resp(513, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
